// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle control unit: FSM states, opcode map,
// ALU operation selectors and the static per-opcode decode bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_ROR   = 3'b001;
    localparam logic [2:0] OP_NAND  = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;
    localparam logic [2:0] OP_MOVE  = 3'b101;
    localparam logic [2:0] OP_BNE   = 3'b110;
    localparam logic [2:0] OP_SET   = 3'b111;

    // Width-independent ALU selector; the top expands ALU_PASS to all-ones.
    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_ROR  = 2'd1,
        ALU_NAND = 2'd2,
        ALU_PASS = 2'd3
    } alu_sel_t;

    typedef struct packed {
        alu_sel_t alu_sel;
        logic     alu_src;
        logic     mem_to_reg;
        logic     is_load;
        logic     is_store;
        logic     is_branch;
        logic     writes_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_sel:    ALU_PASS,
        alu_src:    1'b0,
        mem_to_reg: 1'b0,
        is_load:    1'b0,
        is_store:   1'b0,
        is_branch:  1'b0,
        writes_reg: 1'b0
    };

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: latched opcode -> static control bundle.
// Any opcode outside the 3-bit map (when widened) decodes as NOP.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int MCODEBITS = 3
) (
    input  logic [MCODEBITS-1:0] opcode,
    output ctrl_t                ctrl
);

    logic       in_range;
    logic [2:0] op3;

    assign in_range = ((opcode >> 3) == '0);
    assign op3      = opcode[2:0];

    always_comb begin
        ctrl = CTRL_NOP;
        if (in_range) begin
            case (op3)
                OP_ADD: begin
                    ctrl.alu_sel    = ALU_ADD;
                    ctrl.writes_reg = 1'b1;
                end
                OP_ROR: begin
                    ctrl.alu_sel    = ALU_ROR;
                    ctrl.writes_reg = 1'b1;
                end
                OP_NAND: begin
                    ctrl.alu_sel    = ALU_NAND;
                    ctrl.writes_reg = 1'b1;
                end
                OP_LOAD: begin
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.is_load    = 1'b1;
                    ctrl.writes_reg = 1'b1;
                end
                OP_STORE: begin
                    ctrl.alu_src  = 1'b1;
                    ctrl.is_store = 1'b1;
                end
                OP_MOVE: begin
                    ctrl.writes_reg = 1'b1;
                end
                OP_BNE: begin
                    ctrl.is_branch = 1'b1;
                end
                OP_SET: begin
                    ctrl.alu_src    = 1'b1;
                    ctrl.writes_reg = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, holds the
// latched opcode and counts retired instructions.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MCODEBITS = 3,
    parameter int OPWIDTH   = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 start,
    input  logic                 stop_req,
    input  logic                 instr_valid,
    input  logic [MCODEBITS-1:0] opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCSrc,
    output logic                 ALUSrc,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 busy,
    output logic [CNT_W-1:0]     retired
);

    localparam logic [OPWIDTH-1:0] ALUOP_PASS = '1;

    state_t               state_reg;
    state_t               state_next;
    logic [MCODEBITS-1:0] op_reg;
    logic [CNT_W-1:0]     retired_reg;
    logic                 retire;
    ctrl_t                ctrl;
    logic [OPWIDTH-1:0]   alu_op_dec;

    ctrl_decode #(
        .MCODEBITS(MCODEBITS)
    ) u_decode (
        .opcode(op_reg),
        .ctrl  (ctrl)
    );

    assign alu_op_dec = (ctrl.alu_sel == ALU_PASS) ? ALUOP_PASS
                                                   : OPWIDTH'(ctrl.alu_sel);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            op_reg      <= '0;
            retired_reg <= '0;
        end else begin
            if (state_reg == FETCH && instr_valid) begin
                op_reg <= opcode;
            end
            if (retire) begin
                retired_reg <= retired_reg + 1'b1;
            end
        end
    end

    // Retire is the single point where the PC advances and the count bumps;
    // stop_req is only looked at here.
    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        unique case (state_reg)
            IDLE:   if (start) state_next = FETCH;
            FETCH:  if (instr_valid) state_next = DECODE;
            DECODE: state_next = EXEC;
            EXEC: begin
                if (ctrl.is_branch) begin
                    retire = 1'b1;
                end else if (ctrl.is_load || ctrl.is_store) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    if (ctrl.is_store) begin
                        retire = 1'b1;
                    end else begin
                        state_next = WB;
                    end
                end
            end
            WB:      retire = 1'b1;
            default: state_next = IDLE;
        endcase
        if (retire) begin
            state_next = stop_req ? IDLE : FETCH;
        end
    end

    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = retire;
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = ALUOP_PASS;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        if (state_reg == DECODE || state_reg == EXEC ||
            state_reg == MEM    || state_reg == WB) begin
            ALUOp    = alu_op_dec;
            ALUSrc   = ctrl.alu_src;
            MemtoReg = ctrl.mem_to_reg;
        end
        case (state_reg)
            FETCH: IRWrite = instr_valid;
            EXEC:  PCSrc   = ctrl.is_branch & ~zero;
            MEM: begin
                MemRead  = ctrl.is_load;
                MemWrite = ctrl.is_store;
            end
            WB:    RegWrite = ctrl.writes_reg;
            default: ;
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control (4-bit opcodes, 4-bit
// retire counter) plus hand sequences for reset, start/stop and wrap.
module tb_multicycle_control;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       start, stop_req, instr_valid, zero, mem_ready;
    logic [3:0] opcode;
    logic       IRWrite, PCWrite, PCSrc, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, busy;
    logic [2:0] ALUOp;
    logic [3:0] retired;

    int total = 0;
    int bad   = 0;
    int cnt_model = 0;

    always #5 Clk = ~Clk;

    multicycle_control #(
        .MCODEBITS(4),
        .OPWIDTH  (3),
        .CNT_W    (4)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .stop_req   (stop_req),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .ALUSrc     (ALUSrc),
        .ALUOp      (ALUOp),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .busy       (busy),
        .retired    (retired)
    );

    typedef struct {
        logic [3:0] op;
        bit         zero;
        int         fw;       // cycles instr_valid is held low in FETCH
        int         rdy_from; // mem_ready high from this cycle (relative to valid fetch)
        bit         stop;
        int         cyc;
        int         rd;
        int         wr;
        int         rw;
        int         pcsrc;
        int         aluop;
        int         alusrc;
        int         m2r;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 after retire.
    task automatic run_vec(input vec_t v, input string nm);
        int  cyc = 0;
        int  c;
        int  n_ir = 0, n_rd = 0, n_wr = 0, n_rw = 0;
        int  exec_aluop = -1, r_pcsrc = -1, r_src = -1, r_m2r = -1;
        bit  done = 1'b0;
        while (!done && cyc < 40) begin
            cyc++;
            c           = cyc - v.fw;
            opcode      = v.op;
            zero        = v.zero;
            stop_req    = v.stop;
            instr_valid = (c >= 1);
            mem_ready   = (c >= v.rdy_from);
            @(negedge Clk);
            if (IRWrite)  n_ir++;
            if (MemRead)  n_rd++;
            if (MemWrite) n_wr++;
            if (RegWrite) n_rw++;
            if (c == 3) exec_aluop = int'(ALUOp);
            if (PCWrite) begin
                done    = 1'b1;
                r_pcsrc = int'(PCSrc);
                r_src   = int'(ALUSrc);
                r_m2r   = int'(MemtoReg);
            end
            @(posedge Clk);
            #1;
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        stop_req    = 1'b0;
        chk({nm, ".retire_seen"}, int'(done), 1);
        chk({nm, ".cycles"}, cyc, v.cyc);
        chk({nm, ".irwrite"}, n_ir, 1);
        chk({nm, ".memread"}, n_rd, v.rd);
        chk({nm, ".memwrite"}, n_wr, v.wr);
        chk({nm, ".regwrite"}, n_rw, v.rw);
        chk({nm, ".pcsrc"}, r_pcsrc, v.pcsrc);
        chk({nm, ".aluop"}, exec_aluop, v.aluop);
        chk({nm, ".alusrc"}, r_src, v.alusrc);
        chk({nm, ".memtoreg"}, r_m2r, v.m2r);
        cnt_model = (cnt_model + 1) % 16;
        chk({nm, ".retired"}, int'(retired), cnt_model);
        chk({nm, ".busy_after"}, int'(busy), v.stop ? 0 : 1);
        $display("vec %s op=%0h cycles=%0d retired=%0d", nm, v.op, cyc, retired);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
    endtask

    vec_t vecs[14];
    vec_t v_add_stop;
    vec_t v_set;

    initial begin
        vecs[0]  = '{4'h0, 1'b0, 0, 1, 1'b0, 4, 0, 0, 1, 0, 0, 0, 0}; // ADD
        vecs[1]  = '{4'h1, 1'b0, 0, 1, 1'b0, 4, 0, 0, 1, 0, 1, 0, 0}; // ROR
        vecs[2]  = '{4'h2, 1'b0, 2, 1, 1'b0, 6, 0, 0, 1, 0, 2, 0, 0}; // NAND, late fetch
        vecs[3]  = '{4'h3, 1'b0, 0, 4, 1'b0, 5, 1, 0, 1, 0, 7, 1, 1}; // LOAD, no wait
        vecs[4]  = '{4'h3, 1'b0, 0, 6, 1'b1, 7, 3, 0, 1, 0, 7, 1, 1}; // LOAD, 3 MEM cycles, stop
        vecs[5]  = '{4'h3, 1'b0, 0, 1, 1'b0, 5, 1, 0, 1, 0, 7, 1, 1}; // LOAD, early mem_ready ignored
        vecs[6]  = '{4'h4, 1'b0, 0, 4, 1'b0, 4, 0, 1, 0, 0, 7, 1, 0}; // STORE, no wait
        vecs[7]  = '{4'h4, 1'b0, 1, 5, 1'b0, 6, 0, 2, 0, 0, 7, 1, 0}; // STORE, late fetch + 1 wait
        vecs[8]  = '{4'h5, 1'b0, 0, 1, 1'b0, 4, 0, 0, 1, 0, 7, 0, 0}; // MOVE
        vecs[9]  = '{4'h6, 1'b0, 0, 1, 1'b0, 3, 0, 0, 0, 1, 7, 0, 0}; // BNE taken
        vecs[10] = '{4'h6, 1'b1, 0, 1, 1'b1, 3, 0, 0, 0, 0, 7, 0, 0}; // BNE not taken, stop
        vecs[11] = '{4'h7, 1'b0, 0, 1, 1'b0, 4, 0, 0, 1, 0, 7, 1, 0}; // SET
        vecs[12] = '{4'h8, 1'b0, 0, 1, 1'b0, 4, 0, 0, 0, 0, 7, 0, 0}; // widened opcode -> NOP
        vecs[13] = '{4'hF, 1'b1, 0, 1, 1'b1, 4, 0, 0, 0, 0, 7, 0, 0}; // NOP, stop
        v_add_stop = '{4'h0, 1'b0, 0, 1, 1'b1, 4, 0, 0, 1, 0, 0, 0, 0};
        v_set      = '{4'h7, 1'b0, 0, 1, 1'b0, 4, 0, 0, 1, 0, 7, 1, 0};

        Reset_n = 1'b0; start = 1'b0; stop_req = 1'b0; instr_valid = 1'b0;
        zero = 1'b0; mem_ready = 1'b0; opcode = 4'h0;
        repeat (2) @(posedge Clk);
        #2;
        chk("reset.busy", int'(busy), 0);
        chk("reset.retired", int'(retired), 0);
        chk("reset.aluop", int'(ALUOp), 7);
        chk("reset.strobes", int'({IRWrite, PCWrite, PCSrc, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite}), 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // IDLE holds without start even with fetch/memory inputs active
        instr_valid = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        chk("idle.hold_busy", int'(busy), 0);
        chk("idle.hold_irwrite", int'(IRWrite), 0);
        instr_valid = 1'b0; mem_ready = 1'b0;

        pulse_start();
        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            if (vecs[i].stop && i != 13) pulse_start();
        end

        // start held through an instruction and still high with stop_req at retire
        start = 1'b1;
        @(posedge Clk);
        #1;
        run_vec(v_add_stop, "start_stop");
        chk("start_stop.idle_one_cycle", int'(busy), 0);
        @(posedge Clk);
        #1;
        chk("start_stop.resampled", int'(busy), 1);
        start = 1'b0;

        // counter wrap with CNT_W=4: 17 retirements from reset
        #1 Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        cnt_model = 0;
        @(posedge Clk);
        #1;
        pulse_start();
        for (int i = 1; i <= 17; i++) begin
            v_set.stop = (i == 17);
            run_vec(v_set, $sformatf("set%0d", i));
        end
        chk("wrap.retired", int'(retired), 1);
        chk("wrap.busy", int'(busy), 0);

        // reset asserted in the middle of a LOAD's MEM wait
        pulse_start();
        opcode = 4'h3; instr_valid = 1'b1; mem_ready = 1'b0;
        @(posedge Clk); #1;
        instr_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("midmem.memread", int'(MemRead), 1);
        chk("midmem.busy", int'(busy), 1);
        #1 Reset_n = 1'b0;
        #1;
        chk("midmem.reset_strobes", int'({IRWrite, PCWrite, PCSrc, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite}), 0);
        chk("midmem.reset_aluop", int'(ALUOp), 7);
        chk("midmem.reset_busy", int'(busy), 0);
        chk("midmem.reset_retired", int'(retired), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        mem_ready = 1'b1;
        @(posedge Clk);
        #1;
        chk("midmem.after_release_busy", int'(busy), 0);
        chk("midmem.after_release_memread", int'(MemRead), 0);
        mem_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
